alarm_sequencer: RTL and testbench

ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

---
 rtl/alarm_sequencer_if.sv | 35 +++
 rtl/alarm_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_alarm_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_sequencer_if.sv
// Purpose : bundles the alarm sequencer's time, button and tone-request signals.
// Latency : n/a (wiring only).
// Backpressure: none; all signals are levels or one-cycle pulses.
// Ports   : master = time/button source (drives inputs, reads tones/status);
//           slave  = alarm_sequencer (reads inputs, drives tones/status).
interface alarm_sequencer_if;
  logic       sec_tick;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic [4:0] al_hour;
  logic [5:0] al_min;
  logic       al_en;
  logic       chime_en;
  logic       snooze;
  logic       stop;
  logic       timer_done;
  logic       alarm;
  logic       alarm2;
  logic       alarm3;
  logic       ringing;
  logic       snoozed;

  modport master (
    output sec_tick, cur_hour, cur_min, cur_sec, al_hour, al_min,
           al_en, chime_en, snooze, stop, timer_done,
    input  alarm, alarm2, alarm3, ringing, snoozed
  );

  modport slave (
    input  sec_tick, cur_hour, cur_min, cur_sec, al_hour, al_min,
           al_en, chime_en, snooze, stop, timer_done,
    output alarm, alarm2, alarm3, ringing, snoozed
  );
endinterface

// File: rtl/alarm_sequencer.sv
// Purpose : alarm-clock FSM (IDLE/RING[/SNOOZE]) plus hourly chime and timer-expiry tone requests.
// Latency : every output is registered; a qualifying input shows on the outputs one cycle later.
// Backpressure: none; inputs are one-cycle pulses or levels, sampled every cycle.
// Ports   : clk, rst_n (async, active-low); bus = alarm_sequencer_if.slave carrying
//           sec_tick, cur_*/al_* times, al_en, chime_en, snooze, stop, timer_done in and
//           alarm (alarm clock), alarm2 (chime), alarm3 (timer), ringing, snoozed out.
// Option  : define ALARM_SNOOZE_EN to build the SNOOZE state; otherwise snooze is ignored
//           and snoozed is tied low.
module alarm_sequencer #(
  parameter int ALARM_SEC  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int CHIME_SEC  = 2,
  parameter int TIMER_SEC  = 10
) (
  input logic               clk,
  input logic               rst_n,
  alarm_sequencer_if.slave  bus
);

  localparam int RING_W  = $clog2(ALARM_SEC + 1);
  localparam int CHIME_W = $clog2(CHIME_SEC + 1);
  localparam int TIMER_W = $clog2(TIMER_SEC + 1);

  localparam logic [RING_W-1:0]  RING_LOAD  = RING_W'(ALARM_SEC);
  localparam logic [CHIME_W-1:0] CHIME_LOAD = CHIME_W'(CHIME_SEC);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMER_SEC);

`ifdef ALARM_SNOOZE_EN
  localparam int SNZ_W = $clog2(SNOOZE_MIN * 60 + 1);
  localparam logic [SNZ_W-1:0] SNZ_LOAD = SNZ_W'(SNOOZE_MIN * 60);

  typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2} state_t;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, RING = 1'b1} state_t;
`endif

  state_t               state, state_nxt;
  logic [RING_W-1:0]    ring_cnt, ring_nxt;
  logic                 phase, phase_nxt;
  logic [CHIME_W-1:0]   chime_cnt, chime_nxt;
  logic [TIMER_W-1:0]   timer_cnt, timer_nxt;
  logic                 alarm_q, alarm2_q, alarm3_q, ringing_q;
  logic                 match;
  logic                 chime_hit;

`ifdef ALARM_SNOOZE_EN
  logic [SNZ_W-1:0]     snz_cnt, snz_nxt;
  logic                 snoozed_q;
`else
  logic                 unused_snooze;
  assign unused_snooze = bus.snooze;
`endif

  // Alarm time is only compared on the tick that lands on second 0.
  assign match = bus.sec_tick && bus.al_en &&
                 (bus.cur_hour == bus.al_hour) &&
                 (bus.cur_min  == bus.al_min)  &&
                 (bus.cur_sec  == 6'd0);

  assign chime_hit = bus.sec_tick && bus.chime_en &&
                     (bus.cur_min == 6'd0) && (bus.cur_sec == 6'd0);

  // Next-state and next-counter logic for the alarm FSM.
  always_comb begin
    state_nxt = state;
    ring_nxt  = ring_cnt;
    phase_nxt = phase;
`ifdef ALARM_SNOOZE_EN
    snz_nxt   = snz_cnt;
`endif

    case (state)
      IDLE: begin
        if (match) begin
          state_nxt = RING;
          ring_nxt  = RING_LOAD;
          phase_nxt = 1'b1;
        end
      end

      RING: begin
        // stop and disarm beat snooze, and both beat the tick.
        if (!bus.al_en || bus.stop) begin
          state_nxt = IDLE;
        end
`ifdef ALARM_SNOOZE_EN
        else if (bus.snooze) begin
          state_nxt = SNOOZE;
          snz_nxt   = SNZ_LOAD;
        end
`endif
        else if (bus.sec_tick) begin
          phase_nxt = ~phase;
          if (ring_cnt <= RING_W'(1)) begin
            state_nxt = IDLE;
          end else begin
            ring_nxt = ring_cnt - 1'b1;
          end
        end
      end

`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (!bus.al_en || bus.stop) begin
          state_nxt = IDLE;
        end else if (bus.sec_tick) begin
          if (snz_cnt <= SNZ_W'(1)) begin
            state_nxt = RING;
            snz_nxt   = '0;
            ring_nxt  = RING_LOAD;
            phase_nxt = 1'b1;
          end else begin
            snz_nxt = snz_cnt - 1'b1;
          end
        end
      end
`endif

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Leaving the ring/snooze cycle drops every pending count, so nothing lingers in IDLE.
    if (state_nxt == IDLE) begin
      ring_nxt  = '0;
      phase_nxt = 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_nxt   = '0;
`endif
    end
  end

  // Chime and timer tones run independently of the FSM; stop silences both.
  always_comb begin
    chime_nxt = chime_cnt;
    if (bus.stop) begin
      chime_nxt = '0;
    end else if (chime_hit) begin
      chime_nxt = CHIME_LOAD;
    end else if (bus.sec_tick && (chime_cnt != '0)) begin
      chime_nxt = chime_cnt - 1'b1;
    end

    timer_nxt = timer_cnt;
    if (bus.stop) begin
      timer_nxt = '0;
    end else if (bus.timer_done) begin
      timer_nxt = TIMER_LOAD;
    end else if (bus.sec_tick && (timer_cnt != '0)) begin
      timer_nxt = timer_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ring_cnt  <= '0;
      phase     <= 1'b0;
      chime_cnt <= '0;
      timer_cnt <= '0;
      alarm_q   <= 1'b0;
      alarm2_q  <= 1'b0;
      alarm3_q  <= 1'b0;
      ringing_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      ring_cnt  <= ring_nxt;
      phase     <= phase_nxt;
      chime_cnt <= chime_nxt;
      timer_cnt <= timer_nxt;
      // Outputs are registered from next-state values so they track the state register exactly.
      alarm_q   <= (state_nxt == RING) && phase_nxt;
      alarm2_q  <= (chime_nxt != '0);
      alarm3_q  <= (timer_nxt != '0);
      ringing_q <= (state_nxt == RING);
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snz_cnt   <= '0;
      snoozed_q <= 1'b0;
    end else begin
      snz_cnt   <= snz_nxt;
      snoozed_q <= (state_nxt == SNOOZE);
    end
  end

  assign bus.snoozed = snoozed_q;
`else
  assign bus.snoozed = 1'b0;
`endif

  assign bus.alarm   = alarm_q;
  assign bus.alarm2  = alarm2_q;
  assign bus.alarm3  = alarm3_q;
  assign bus.ringing = ringing_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Purpose : self-checking bench for alarm_sequencer (directed scenarios + randomized run vs. a seconds-level model).
// Latency : outputs checked on the falling edge after each driven cycle.
// Backpressure: none; stimulus is one cycle per call.
module tb_alarm_sequencer;
  localparam int ALARM_SEC  = 4;
  localparam int SNOOZE_MIN = 1;
  localparam int CHIME_SEC  = 2;
  localparam int TIMER_SEC  = 3;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alarm_sequencer_if bus();

  alarm_sequencer #(
    .ALARM_SEC (ALARM_SEC),
    .SNOOZE_MIN(SNOOZE_MIN),
    .CHIME_SEC (CHIME_SEC),
    .TIMER_SEC (TIMER_SEC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Bench-side stimulus; wall time kept as seconds since midnight.
  int         tsec;
  logic       tk, snz, stp, tdone, en, cen;
  logic [4:0] ah;
  logic [5:0] am;

  assign bus.sec_tick   = tk;
  assign bus.cur_hour   = 5'(tsec / 3600);
  assign bus.cur_min    = 6'((tsec / 60) % 60);
  assign bus.cur_sec    = 6'(tsec % 60);
  assign bus.al_hour    = ah;
  assign bus.al_min     = am;
  assign bus.al_en      = en;
  assign bus.chime_en   = cen;
  assign bus.snooze     = snz;
  assign bus.stop       = stp;
  assign bus.timer_done = tdone;

  int vecs = 0;
  int miss = 0;

  // Reference model: ringing for a number of elapsed seconds, snoozing with seconds left,
  // chime/timer as seconds of tone remaining.
  bit m_ring, m_snz;
  int m_elapsed, m_snooze_left, m_chime, m_timer;

  function automatic logic [4:0] obs_vec();
    return {bus.alarm, bus.alarm2, bus.alarm3, bus.ringing, bus.snoozed};
  endfunction

  function automatic logic [4:0] exp_vec();
    return {m_ring && (m_elapsed % 2 == 0), m_chime > 0, m_timer > 0, m_ring, m_snz};
  endfunction

  task automatic model_reset();
    m_ring = 0; m_snz = 0; m_elapsed = 0; m_snooze_left = 0; m_chime = 0; m_timer = 0;
  endtask

  task automatic model_step();
    int h, m, s;
    bit hit;
    h = tsec / 3600; m = (tsec / 60) % 60; s = tsec % 60;
    hit = tk && en && (h == int'(ah)) && (m == int'(am)) && (s == 0);
    if (!en) begin
      m_ring = 0; m_snz = 0;
    end else if (m_ring) begin
      if (stp) m_ring = 0;
      else if (snz && SNZ) begin
        m_ring = 0; m_snz = 1; m_snooze_left = SNOOZE_MIN * 60;
      end else if (tk) begin
        m_elapsed++;
        if (m_elapsed >= ALARM_SEC) m_ring = 0;
      end
    end else if (m_snz) begin
      if (stp) m_snz = 0;
      else if (tk) begin
        m_snooze_left--;
        if (m_snooze_left == 0) begin
          m_snz = 0; m_ring = 1; m_elapsed = 0;
        end
      end
    end else if (hit) begin
      m_ring = 1; m_elapsed = 0;
    end

    if (stp) m_chime = 0;
    else if (tk && cen && m == 0 && s == 0) m_chime = CHIME_SEC;
    else if (tk && m_chime > 0) m_chime--;

    if (stp) m_timer = 0;
    else if (tdone) m_timer = TIMER_SEC;
    else if (tk && m_timer > 0) m_timer--;
  endtask

  // One clock cycle of stimulus; called and returns on a falling edge.
  task automatic cyc(input bit t, input bit s_n, input bit s_p, input bit td);
    if (t) tsec = (tsec + 1) % 86400;
    tk = t; snz = s_n; stp = s_p; tdone = td;
    @(posedge clk);
    model_step();
    @(negedge clk);
    tk = 0; snz = 0; stp = 0; tdone = 0;
  endtask

  task automatic start_ring();
    ah = 5'd7; am = 6'd30; en = 1'b1;
    tsec = 7 * 3600 + 30 * 60 - 1;
    cyc(1, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs++;
    if (obs_vec() !== 5'b00000) begin
      miss++; $display("FAIL reset_state got=%b exp=%b", obs_vec(), 5'b00000);
    end
    tdone = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tdone = 1'b0;
    vecs++;
    if (obs_vec() !== 5'b00000) begin
      miss++; $display("FAIL reset_holds got=%b exp=%b", obs_vec(), 5'b00000);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_ring();
    logic [4:0] tab [4];
    logic [4:0] prev;
    tab[0] = 5'b00010; tab[1] = 5'b10010; tab[2] = 5'b00010; tab[3] = 5'b00000;
    ah = 5'd7; am = 6'd30; en = 1'b1; cen = 1'b0;
    tsec = 7 * 3600 + 29 * 60 + 58;
    cyc(1, 0, 0, 0);
    vecs++;
    if (obs_vec() !== 5'b00000) begin
      miss++; $display("FAIL ring_prematch got=%b exp=%b", obs_vec(), 5'b00000);
    end
    cyc(1, 0, 0, 0);
    vecs++;
    if (obs_vec() !== 5'b10010) begin
      miss++; $display("FAIL ring_start got=%b exp=%b", obs_vec(), 5'b10010);
    end
    prev = 5'b10010;
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0);
      vecs++;
      if (obs_vec() !== prev) begin
        miss++; $display("FAIL ring_hold k=%0d got=%b exp=%b", k, obs_vec(), prev);
      end
      cyc(1, 0, 0, 0);
      vecs++;
      if (obs_vec() !== tab[k]) begin
        miss++; $display("FAIL ring_pattern k=%0d got=%b exp=%b", k, obs_vec(), tab[k]);
      end
      prev = tab[k];
    end
  endtask

  task automatic test_al_en_drop();
    start_ring();
    en = 1'b0;
    cyc(0, 0, 0, 0);
    vecs++;
    if (obs_vec() !== 5'b00000) begin
      miss++; $display("FAIL al_en_drop got=%b exp=%b", obs_vec(), 5'b00000);
    end
    en = 1'b1;
  endtask

  task automatic test_snooze();
    start_ring();
`ifdef ALARM_SNOOZE_EN
    cyc(0, 1, 0, 0);
    vecs++;
    if (obs_vec() !== 5'b00001) begin
      miss++; $display("FAIL snooze_enter got=%b exp=%b", obs_vec(), 5'b00001);
    end
    for (int i = 1; i < 60; i++) begin
      cyc(1, 0, 0, 0);
      vecs++;
      if (obs_vec() !== 5'b00001) begin
        miss++; $display("FAIL snooze_wait i=%0d got=%b exp=%b", i, obs_vec(), 5'b00001);
      end
    end
    cyc(1, 0, 0, 0);
    vecs++;
    if (obs_vec() !== 5'b10010) begin
      miss++; $display("FAIL snooze_rering got=%b exp=%b", obs_vec(), 5'b10010);
    end
`else
    cyc(0, 1, 0, 0);
    vecs++;
    if (obs_vec() !== 5'b10010) begin
      miss++; $display("FAIL snooze_ignored got=%b exp=%b", obs_vec(), 5'b10010);
    end
    cyc(1, 0, 0, 0);
    vecs++;
    if (obs_vec() !== 5'b00010) begin
      miss++; $display("FAIL snooze_ignored_tick got=%b exp=%b", obs_vec(), 5'b00010);
    end
`endif
    cyc(0, 0, 1, 0);
    vecs++;
    if (obs_vec() !== 5'b00000) begin
      miss++; $display("FAIL snooze_stop got=%b exp=%b", obs_vec(), 5'b00000);
    end
  endtask

  task automatic test_stop_snooze();
    start_ring();
    cyc(0, 1, 1, 0);
    vecs++;
    if (obs_vec() !== 5'b00000) begin
      miss++; $display("FAIL stop_vs_snooze got=%b exp=%b", obs_vec(), 5'b00000);
    end
    for (int i = 0; i < 62; i++) begin
      cyc(1, 0, 0, 0);
      vecs++;
      if (obs_vec() !== 5'b00000) begin
        miss++; $display("FAIL no_rering i=%0d got=%b exp=%b", i, obs_vec(), 5'b00000);
      end
    end
    start_ring();
    cyc(1, 0, 1, 0);
    vecs++;
    if (obs_vec() !== 5'b00000) begin
      miss++; $display("FAIL stop_vs_tick got=%b exp=%b", obs_vec(), 5'b00000);
    end
  endtask

  task automatic test_chime();
    logic [4:0] tab [4];
    tab[0] = 5'b01000; tab[1] = 5'b01000; tab[2] = 5'b01000; tab[3] = 5'b00000;
    cen = 1'b1;
    tsec = 11 * 3600 + 59 * 60 + 59;
    for (int k = 0; k < 4; k++) begin
      cyc(k != 1, 0, 0, 0);
      vecs++;
      if (obs_vec() !== tab[k]) begin
        miss++; $display("FAIL chime k=%0d got=%b exp=%b", k, obs_vec(), tab[k]);
      end
    end
    cen = 1'b0;
    tsec = 12 * 3600 + 59 * 60 + 59;
    cyc(1, 0, 0, 0);
    vecs++;
    if (obs_vec() !== 5'b00000) begin
      miss++; $display("FAIL chime_disabled got=%b exp=%b", obs_vec(), 5'b00000);
    end
    cen = 1'b1;
    tsec = 13 * 3600 + 59 * 60 + 59;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    vecs++;
    if (obs_vec() !== 5'b00000) begin
      miss++; $display("FAIL chime_stop got=%b exp=%b", obs_vec(), 5'b00000);
    end
    cen = 1'b0;
  endtask

  task automatic test_timer();
    cyc(0, 0, 0, 1);
    vecs++;
    if (obs_vec() !== 5'b00100) begin
      miss++; $display("FAIL timer_start got=%b exp=%b", obs_vec(), 5'b00100);
    end
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    for (int k = 1; k <= 3; k++) begin
      cyc(1, 0, 0, 0);
      vecs++;
      if (obs_vec() !== ((k < 3) ? 5'b00100 : 5'b00000)) begin
        miss++; $display("FAIL timer_retrigger k=%0d got=%b exp=%b", k, obs_vec(),
                         (k < 3) ? 5'b00100 : 5'b00000);
      end
    end
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);
    vecs++;
    if (obs_vec() !== 5'b00000) begin
      miss++; $display("FAIL timer_stop got=%b exp=%b", obs_vec(), 5'b00000);
    end
  endtask

  task automatic test_reset_mid();
    start_ring();
`ifdef ALARM_SNOOZE_EN
    cyc(0, 1, 0, 0);
    repeat (5) cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    vecs++;
    if (obs_vec() !== 5'b00101) begin
      miss++; $display("FAIL pre_reset got=%b exp=%b", obs_vec(), 5'b00101);
    end
`else
    cyc(0, 0, 0, 1);
    vecs++;
    if (obs_vec() !== 5'b10110) begin
      miss++; $display("FAIL pre_reset got=%b exp=%b", obs_vec(), 5'b10110);
    end
`endif
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if (obs_vec() !== 5'b00000) begin
      miss++; $display("FAIL async_reset got=%b exp=%b", obs_vec(), 5'b00000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 70; i++) begin
      cyc(1, 0, 0, 0);
      vecs++;
      if (obs_vec() !== 5'b00000) begin
        miss++; $display("FAIL post_reset i=%0d got=%b exp=%b", i, obs_vec(), 5'b00000);
      end
    end
  endtask

  task automatic test_random();
    int base;
    bit t, s_n, s_p, td;
    ah = 5'($urandom_range(0, 23));
    am = 6'($urandom_range(0, 59));
    base = int'(ah) * 3600 + int'(am) * 60;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0)
        tsec = (base - int'($urandom_range(1, 3)) + 86400) % 86400;
      else if ($urandom_range(0, 199) == 0)
        tsec = (int'($urandom_range(0, 23)) * 3600 - int'($urandom_range(1, 2)) + 86400) % 86400;
      en = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 99) == 0) cen = ~cen;
      t   = ($urandom_range(0, 2) == 0);
      s_n = ($urandom_range(0, 29) == 0);
      s_p = ($urandom_range(0, 59) == 0);
      td  = ($urandom_range(0, 39) == 0);
      cyc(t, s_n, s_p, td);
      vecs++;
      if (obs_vec() !== exp_vec()) begin
        miss++; $display("FAIL random cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    tk = 0; snz = 0; stp = 0; tdone = 0; en = 0; cen = 0;
    ah = 5'd7; am = 6'd30; tsec = 0;
    model_reset();
    test_reset();
    test_ring();
    test_al_en_drop();
    test_snooze();
    test_stop_snooze();
    test_chime();
    test_timer();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
